// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: shares one DDR AXI read-address channel among NREQ requesters and steers R ownership.
// Define DDR_RD_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module ddr_rd_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       ddr_ready,
    input  logic [NREQ-1:0]            req_arvalid,
    input  logic [32*NREQ-1:0]         req_araddr,
    input  logic [8*NREQ-1:0]          req_arlen,
    output logic [NREQ-1:0]            req_arready,
    output logic                       m_arvalid,
    output logic [31:0]                m_araddr,
    output logic [7:0]                 m_arlen,
    input  logic                       m_arready,
    input  logic                       m_rvalid,
    input  logic                       m_rready,
    input  logic                       m_rlast,
    output logic [$clog2(NREQ)-1:0]    r_owner,
    output logic                       r_owner_valid,
    output logic [$clog2(MAX_OUTST):0] outst_cnt,
    output logic                       rd_err
);
    localparam int IDXW = $clog2(NREQ);
    localparam int PTRW = $clog2(MAX_OUTST);
    localparam int CNTW = PTRW + 1;

    typedef enum logic [1:0] {WAIT_RDY, IDLE, ISSUE} state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic            r_arvalid;
    logic [31:0]     r_araddr;
    logic [7:0]      r_arlen;
    logic [IDXW-1:0] r_gntIdx;

    logic [IDXW-1:0] r_fifo [MAX_OUTST];
    logic [PTRW-1:0] r_wrPtr;
    logic [PTRW-1:0] r_rdPtr;
    logic [CNTW-1:0] r_cnt;
    logic            r_rdErr;

    logic            w_anyReq;
    logic            w_canGrant;
    logic            w_grant;
    logic            w_arHs;
    logic            w_cpl;
    logic            w_pop;
    logic [IDXW-1:0] w_winIdx;
    logic [IDXW-1:0] w_cand;
    logic [31:0]     w_winAddr;
    logic [7:0]      w_winLen;

    assign w_anyReq   = |req_arvalid;
    assign w_canGrant = (r_cnt < CNTW'(MAX_OUTST));
    assign w_grant    = (r_state == IDLE) && w_anyReq && w_canGrant;
    assign w_arHs     = (r_state == ISSUE) && r_arvalid && m_arready;
    assign w_cpl      = m_rvalid & m_rready & m_rlast;
    assign w_pop      = w_cpl && (r_cnt != '0);

`ifdef DDR_RD_ARB_RR_EN
    logic [IDXW-1:0] r_rrPtr;

    // Scanning downward lets the candidate nearest the pointer overwrite the others.
    always_comb begin
        w_winIdx = '0;
        w_cand   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = IDXW'((int'(r_rrPtr) + k) % NREQ);
            if (req_arvalid[w_cand]) begin
                w_winIdx = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rrPtr <= '0;
        end else if (w_arHs) begin
            r_rrPtr <= IDXW'((int'(r_gntIdx) + 1) % NREQ);
        end
    end
`else
    always_comb begin
        w_winIdx = '0;
        w_cand   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = IDXW'(k);
            if (req_arvalid[w_cand]) begin
                w_winIdx = w_cand;
            end
        end
    end
`endif

    always_comb begin
        w_winAddr = '0;
        w_winLen  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winIdx == IDXW'(i)) begin
                w_winAddr = req_araddr[32*i +: 32];
                w_winLen  = req_arlen[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= WAIT_RDY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            WAIT_RDY: if (ddr_ready) w_nextState = IDLE;
            IDLE:     if (w_grant)   w_nextState = ISSUE;
            ISSUE:    if (w_arHs)    w_nextState = IDLE;
            default:                 w_nextState = WAIT_RDY;
        endcase
    end

    always_comb begin
        req_arready = '0;
        if (w_arHs) begin
            req_arready[r_gntIdx] = 1'b1;
        end
        m_arvalid     = r_arvalid;
        m_araddr      = r_araddr;
        m_arlen       = r_arlen;
        outst_cnt     = r_cnt;
        rd_err        = r_rdErr;
        r_owner_valid = (r_cnt != '0);
        r_owner       = r_owner_valid ? r_fifo[r_rdPtr] : '0;
    end

    // The AR payload is captured at grant time and held untouched until the handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_gntIdx  <= '0;
        end else if (w_grant) begin
            r_arvalid <= 1'b1;
            r_araddr  <= w_winAddr;
            r_arlen   <= w_winLen;
            r_gntIdx  <= w_winIdx;
        end else if (w_arHs) begin
            r_arvalid <= 1'b0;
        end
    end

    // Ownership FIFO; its occupancy doubles as the outstanding-burst count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_arHs) begin
                r_fifo[r_wrPtr] <= r_gntIdx;
                r_wrPtr         <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_arHs, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rdErr <= 1'b0;
        end else if (w_cpl && (r_cnt == '0)) begin
            r_rdErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter: directed, table-driven checks of grant order, outstanding limit,
// ownership FIFO steering, error flag and reset behaviour of ddr_rd_arbiter.
module tb_ddr_rd_arbiter;
    localparam int NREQ      = 2;
    localparam int MAX_OUTST = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              ddr_ready;
    logic [NREQ-1:0]   req_arvalid;
    logic [32*NREQ-1:0] req_araddr;
    logic [8*NREQ-1:0] req_arlen;
    logic [NREQ-1:0]   req_arready;
    logic              m_arvalid;
    logic [31:0]       m_araddr;
    logic [7:0]        m_arlen;
    logic              m_arready;
    logic              m_rvalid;
    logic              m_rready;
    logic              m_rlast;
    logic [0:0]        r_owner;
    logic              r_owner_valid;
    logic [2:0]        outst_cnt;
    logic              rd_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  mask;
        logic [1:0]  expGnt;
        logic [31:0] expAddr;
        logic [7:0]  expLen;
        logic [2:0]  expCnt;
    } vec_t;

    vec_t vecs [4];

    ddr_rd_arbiter #(.NREQ(NREQ), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rstn(rstn), .ddr_ready(ddr_ready),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arready(req_arready), .m_arvalid(m_arvalid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arready(m_arready), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .m_rlast(m_rlast), .r_owner(r_owner),
        .r_owner_valid(r_owner_valid), .outst_cnt(outst_cnt), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] mask);
        req_arvalid = mask;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulseRlast();
        m_rvalid = 1'b1;
        m_rready = 1'b1;
        m_rlast  = 1'b1;
        tick();
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic waitArvalid(input string name);
        for (int c = 0; c < 8 && m_arvalid !== 1'b1; c++) begin
            tick();
        end
        checkOutput(name, {31'b0, m_arvalid}, 32'd1);
    endtask

    initial begin
        logic expOwner2;

`ifdef DDR_RD_ARB_RR_EN
        vecs[0] = '{2'b11, 2'b01, 32'h1000, 8'd3, 3'd1};
        vecs[1] = '{2'b11, 2'b10, 32'h2000, 8'd7, 3'd2};
        vecs[2] = '{2'b11, 2'b01, 32'h1000, 8'd3, 3'd3};
        vecs[3] = '{2'b11, 2'b10, 32'h2000, 8'd7, 3'd4};
        expOwner2 = 1'b1;
`else
        vecs[0] = '{2'b11, 2'b01, 32'h1000, 8'd3, 3'd1};
        vecs[1] = '{2'b11, 2'b01, 32'h1000, 8'd3, 3'd2};
        vecs[2] = '{2'b11, 2'b01, 32'h1000, 8'd3, 3'd3};
        vecs[3] = '{2'b11, 2'b01, 32'h1000, 8'd3, 3'd4};
        expOwner2 = 1'b0;
`endif

        rstn = 1'b0;
        ddr_ready = 1'b0;
        applyStimulus(2'b00);
        req_araddr = {32'h0000_2000, 32'h0000_1000};
        req_arlen = {8'd7, 8'd3};
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rlast = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;

        checkOutput("rst_arvalid", {31'b0, m_arvalid}, 32'd0);
        checkOutput("rst_araddr", m_araddr, 32'd0);
        checkOutput("rst_arlen", {24'b0, m_arlen}, 32'd0);
        checkOutput("rst_req_arready", {30'b0, req_arready}, 32'd0);
        checkOutput("rst_outst_cnt", {29'b0, outst_cnt}, 32'd0);
        checkOutput("rst_owner_valid", {31'b0, r_owner_valid}, 32'd0);
        checkOutput("rst_owner", {31'b0, r_owner}, 32'd0);
        checkOutput("rst_rd_err", {31'b0, rd_err}, 32'd0);

        // No arbitration before calibration completes.
        applyStimulus(2'b01);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("wait_rdy_arvalid", {31'b0, m_arvalid}, 32'd0);
        end
        ddr_ready = 1'b1;
        tick();
        checkOutput("rdy_edge1_arvalid", {31'b0, m_arvalid}, 32'd0);
        ddr_ready = 1'b0;
        tick();
        checkOutput("rdy_edge2_arvalid", {31'b0, m_arvalid}, 32'd1);
        checkOutput("rdy_edge2_araddr", m_araddr, 32'h1000);
        checkOutput("rdy_edge2_arlen", {24'b0, m_arlen}, 32'd3);

        // Stall: payload stable, no acceptance until the handshake.
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall_arvalid", {31'b0, m_arvalid}, 32'd1);
            checkOutput("stall_araddr", m_araddr, 32'h1000);
            checkOutput("stall_arlen", {24'b0, m_arlen}, 32'd3);
            checkOutput("stall_req_arready", {30'b0, req_arready}, 32'd0);
        end
        m_arready = 1'b1;
        #1;
        checkOutput("hs_req_arready", {30'b0, req_arready}, 32'h1);
        tick();
        applyStimulus(2'b00);
        checkOutput("hs_outst_cnt", {29'b0, outst_cnt}, 32'd1);
        checkOutput("hs_owner_valid", {31'b0, r_owner_valid}, 32'd1);
        checkOutput("hs_owner", {31'b0, r_owner}, 32'd0);
        checkOutput("hs_arvalid_drop", {31'b0, m_arvalid}, 32'd0);

        // Fresh reset, then both requesters held continuously.
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        ddr_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].mask);
            waitArvalid("vec_arvalid_timeout");
            checkOutput("vec_req_arready", {30'b0, req_arready}, {30'b0, vecs[v].expGnt});
            checkOutput("vec_araddr", m_araddr, vecs[v].expAddr);
            checkOutput("vec_arlen", {24'b0, m_arlen}, {24'b0, vecs[v].expLen});
            tick();
            checkOutput("vec_outst_cnt", {29'b0, outst_cnt}, {29'b0, vecs[v].expCnt});
        end

        // Outstanding limit reached: no fifth grant until a completion.
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("full_arvalid", {31'b0, m_arvalid}, 32'd0);
        end
        checkOutput("full_outst_cnt", {29'b0, outst_cnt}, 32'd4);
        checkOutput("full_owner", {31'b0, r_owner}, 32'd0);
        pulseRlast();
        checkOutput("pop1_outst_cnt", {29'b0, outst_cnt}, 32'd3);
        checkOutput("pop1_owner", {31'b0, r_owner}, {31'b0, expOwner2});
        waitArvalid("fifth_arvalid_timeout");
        checkOutput("fifth_req_arready", {30'b0, req_arready}, 32'h1);
        checkOutput("fifth_araddr", m_araddr, 32'h1000);
        tick();
        applyStimulus(2'b00);
        checkOutput("fifth_outst_cnt", {29'b0, outst_cnt}, 32'd4);

        pulseRlast();
        pulseRlast();
        checkOutput("drain_outst_cnt", {29'b0, outst_cnt}, 32'd2);
        checkOutput("drain_owner", {31'b0, r_owner}, {31'b0, expOwner2});

        // Handshake and completion in the same cycle.
        applyStimulus(2'b10);
        waitArvalid("simul_arvalid_timeout");
        m_rvalid = 1'b1;
        m_rready = 1'b1;
        m_rlast = 1'b1;
        #1;
        checkOutput("simul_req_arready", {30'b0, req_arready}, 32'h2);
        tick();
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rlast = 1'b0;
        applyStimulus(2'b00);
        checkOutput("simul_outst_cnt", {29'b0, outst_cnt}, 32'd2);
        checkOutput("simul_owner", {31'b0, r_owner}, 32'd0);
        pulseRlast();
        checkOutput("tail_outst_cnt", {29'b0, outst_cnt}, 32'd1);
        checkOutput("tail_owner", {31'b0, r_owner}, 32'd1);
        pulseRlast();
        checkOutput("empty_outst_cnt", {29'b0, outst_cnt}, 32'd0);
        checkOutput("empty_owner_valid", {31'b0, r_owner_valid}, 32'd0);

        // Completion with nothing outstanding is sticky.
        pulseRlast();
        checkOutput("err_rd_err", {31'b0, rd_err}, 32'd1);
        checkOutput("err_outst_cnt", {29'b0, outst_cnt}, 32'd0);
        repeat (5) tick();
        checkOutput("err_sticky", {31'b0, rd_err}, 32'd1);

        // Reset while an AR is pending.
        m_arready = 1'b0;
        applyStimulus(2'b01);
        waitArvalid("issue_arvalid_timeout");
        rstn = 1'b0;
        tick();
        checkOutput("rst_issue_arvalid", {31'b0, m_arvalid}, 32'd0);
        checkOutput("rst_issue_rd_err", {31'b0, rd_err}, 32'd0);
        rstn = 1'b1;
        ddr_ready = 1'b0;
        m_arready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rst_wait_arvalid", {31'b0, m_arvalid}, 32'd0);
        end
        ddr_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_resume_arvalid", {31'b0, m_arvalid}, 32'd1);
        tick();
        applyStimulus(2'b00);
        checkOutput("rst_resume_outst_cnt", {29'b0, outst_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_rd_arbiter.md
# ddr_rd_arbiter

Shares the single DDR controller AXI read-address channel between `NREQ` requesters (DMA, CPU refill, test engines). Arbitration starts only once `ddr_ready` has been seen. The block issues one AR burst at a time, bounds outstanding bursts to `MAX_OUTST`, and tracks burst ownership in issue order so the R channel can be steered back to the requester that asked for it.

## Interface
- `NREQ`, 2: number of requesters, 2..4.
- `MAX_OUTST`, 4: maximum accepted-but-incomplete bursts, power of two, 2..8.
- Reset is `rstn`: synchronous, active-low. Clock is `clk`.
- `clk`  in  1  system clock.
- `rstn`  in  1  synchronous active-low reset.
- `ddr_ready`  in  1  DDR calibration/init done; level.
- `req_arvalid`  in  NREQ  per-requester read request.
- `req_araddr`  in  32*NREQ  request address, requester i at bits [32i+31:32i].
- `req_arlen`  in  8*NREQ  burst length minus one, requester i at bits [8i+7:8i].
- `req_arready`  out  NREQ  one-hot acceptance pulse.
- `m_arvalid`  out  1  AR valid to the DDR controller.
- `m_araddr`  out  32  AR address.
- `m_arlen`  out  8  AR length.
- `m_arready`  in  1  AR ready from the DDR controller.
- `m_rvalid`, `m_rready`, `m_rlast`  in  1 each  R channel, monitored only.
- `r_owner`  out  clog2(NREQ)  index owning the current R beat.
- `r_owner_valid`  out  1  an owner is known (ownership FIFO not empty).
- `outst_cnt`  out  clog2(MAX_OUTST)+1  number of bursts in flight.
- `rd_err`  out  1  sticky flag: an R last beat arrived with no recorded owner.

## Operation
- **WAIT_RDY**: entered at reset. Move to IDLE on the first cycle `ddr_ready`=1. After that, `ddr_ready` is ignored until the next reset.
- **IDLE**: if any `req_arvalid` is high and `outst_cnt` < `MAX_OUTST`, select a winner and go to ISSUE.
  - Registered in the same edge: the winner's address and length into `m_araddr`/`m_arlen`, the winner's index into `gnt_idx`, and `m_arvalid`<=1.
- **ISSUE**: hold `m_arvalid`, `m_araddr`, `m_arlen` stable until `m_arready`=1. On that handshake cycle:
  - `req_arready[gnt_idx]`=1, combinational (`m_arvalid & m_arready`).
  - Push `gnt_idx` into the ownership FIFO (depth `MAX_OUTST`).
  - Increment `outst_cnt`.
  - `m_arvalid`<=0; return to IDLE.
- Requesters hold `req_arvalid`, address and length stable until their `req_arready`. Deasserting `req_arvalid` before acceptance is illegal and is not checked.
- **Completion**: `m_rvalid & m_rready & m_rlast` pops the FIFO and decrements `outst_cnt`.
  - `r_owner` is the FIFO head.
  - A completion with an empty FIFO sets `rd_err` and leaves the count at 0.
- **Simultaneous AR handshake and completion** in one cycle: push and pop both occur, `outst_cnt` is unchanged.
- The FIFO never overflows, because no grant is made while `outst_cnt`==`MAX_OUTST`.
- **Reset mid-operation**: all state clears and the block returns to WAIT_RDY. Any in-flight AR is abandoned. The system must also reset the controller.

## Timing
- Reset values:
  - `m_arvalid`=0, `m_araddr`=0, `m_arlen`=0.
  - `req_arready`=0, `outst_cnt`=0.
  - `r_owner_valid`=0, `r_owner`=0, `rd_err`=0.
  - Round-robin pointer = 0.
- Request-to-`m_arvalid` latency: 1 cycle from IDLE (request seen at edge N, `m_arvalid` high after edge N).
- Back-to-back throughput: one AR per 2 cycles when `m_arready` is held high.
- `outst_cnt` and `r_owner` update on the edge after the handshake or completion.

## Configuration
- **`DDR_RD_ARB_RR_EN` defined**: round-robin.
  - Search starts at the pointer, which after a handshake becomes `gnt_idx`+1 mod `NREQ`.
  - Any continuously requesting requester is granted within `NREQ` grants.
- **Not defined**: fixed priority, lowest index wins. The pointer logic is not instantiated.

## Test plan
- Assert `req_arvalid[0]` with `ddr_ready`=0 for 20 cycles -> `m_arvalid` stays 0. Raise `ddr_ready` -> `m_arvalid`=1 after 2 edges with `m_araddr`=req0 address.
- Req0 at 0x1000/len 3 and req1 at 0x2000/len 7 held together, `m_arready`=1, RR enabled -> grants alternate 0,1,0,1. Without the macro -> req0 wins every time.
- `MAX_OUTST`=4, 5 requests, no R completions -> 4 AR handshakes, `outst_cnt`=4, `m_arvalid` stays 0. One `rlast` beat -> 5th AR issues.
- `m_arready` held low 10 cycles -> `m_arvalid`, `m_araddr`, `m_arlen` stable throughout, `req_arready` is 0 until the handshake.
- AR handshake in the same cycle as `rlast` with `outst_cnt`=2 -> `outst_cnt` stays 2, `r_owner` advances to the next FIFO entry.
- `rlast` with an empty FIFO -> `rd_err`=1 and stays high until `rstn`=0. Reset during ISSUE -> `m_arvalid`=0 next edge, state WAIT_RDY.
